// File: rtl/enemy_tiro_ctrl.sv
// Enemy fire controller: turns one-hot fire pulses into bullets in a small slot pool,
// moves them down on a periodic tick, retires them at the bottom and reports player hits.
module enemy_tiro_ctrl #(
   parameter int N_INIMIGOS  = 24,
   parameter int N_COLUNAS   = 6,
   parameter int ESP_X       = 16,
   parameter int ESP_Y       = 12,
   parameter int ALT_INIM    = 8,
   parameter int MAX_TIROS   = 4,
   parameter int PERIODO_MOV = 50000,
   parameter int PASSO_Y     = 2,
   parameter int JOG_Y       = 224,
   parameter int LARG_JOG    = 16,
   parameter int LIMITE_Y    = 240
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     restart,
   input  logic [N_INIMIGOS-1:0]    ID_enemy_tiro,
   input  logic [N_INIMIGOS-1:0]    enemy_vivos,
   input  logic [7:0]               bloco_pos_X,
   input  logic [7:0]               bloco_pos_Y,
   input  logic [7:0]               jogador_pos_X,
   output logic                     tiro_aceito,
   output logic                     tiro_descartado,
   output logic                     jogador_atingido,
   output logic [MAX_TIROS-1:0]     tiros_ativos,
   output logic [8*MAX_TIROS-1:0]   tiro_x,
   output logic [8*MAX_TIROS-1:0]   tiro_y
);
   localparam int IW = (N_INIMIGOS > 1) ? $clog2(N_INIMIGOS) : 1;
   localparam int CW = (PERIODO_MOV > 1) ? $clog2(PERIODO_MOV) : 1;
   localparam int SW = (MAX_TIROS > 1) ? $clog2(MAX_TIROS) : 1;

   typedef enum logic {LIVRE, ATIVO} slot_st_t;

   slot_st_t          st_q [MAX_TIROS];
   slot_st_t          st_d [MAX_TIROS];
   logic [7:0]        x_q  [MAX_TIROS];
   logic [7:0]        x_d  [MAX_TIROS];
   logic [7:0]        y_q  [MAX_TIROS];
   logic [7:0]        y_d  [MAX_TIROS];
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              s1_vld_q, s1_vld_d, s1_vivo_q, s1_vivo_d;
   logic [IW-1:0]     s1_idx_q, s1_idx_d;
   logic [7:0]        s1_bx_q, s1_bx_d, s1_by_q, s1_by_d;
   logic              aceito_q, aceito_d, desc_q, desc_d, hit_q, hit_d;

   logic [8:0]        col, row, spawn_x, spawn_y, new_y, px_lo, px_hi;
   logic              tick, found, ok;
   logic [SW-1:0]     slot;

   always_comb begin
      // stage 1: lowest set request bit wins; context sampled alongside it
      s1_vld_d = |ID_enemy_tiro;
      s1_idx_d = '0;
      for (int i = N_INIMIGOS-1; i >= 0; i--)
         if (ID_enemy_tiro[i]) s1_idx_d = IW'(i);
      s1_vivo_d = enemy_vivos[s1_idx_d];
      s1_bx_d   = bloco_pos_X;
      s1_by_d   = bloco_pos_Y;

      // stage 2: spawn coordinates and slot choice from the pre-tick slot state
      col     = 9'(int'(s1_idx_q) % N_COLUNAS);
      row     = 9'(int'(s1_idx_q) / N_COLUNAS);
      spawn_x = {1'b0, s1_bx_q} + col * 9'(ESP_X) + 9'(ESP_X/2);
      spawn_y = {1'b0, s1_by_q} + row * 9'(ESP_Y) + 9'(ALT_INIM);
      found   = 1'b0;
      slot    = '0;
      for (int i = MAX_TIROS-1; i >= 0; i--)
         if (st_q[i] == LIVRE) begin
            found = 1'b1;
            slot  = SW'(i);
         end
      ok       = s1_vld_q && s1_vivo_q && !spawn_x[8] && (spawn_y < 9'(LIMITE_Y)) && found;
      aceito_d = s1_vld_q && ok;
      desc_d   = s1_vld_q && !ok;

      tick  = (cnt_q == CW'(PERIODO_MOV-1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      px_lo = {1'b0, jogador_pos_X};
      px_hi = px_lo + 9'(LARG_JOG-1);
      hit_d = 1'b0;
      new_y = '0;
      for (int i = 0; i < MAX_TIROS; i++) begin
         st_d[i] = st_q[i];
         x_d[i]  = x_q[i];
         y_d[i]  = y_q[i];
         if (tick && st_q[i] == ATIVO) begin
            new_y = {1'b0, y_q[i]} + 9'(PASSO_Y);
            if (new_y >= 9'(JOG_Y) && {1'b0, x_q[i]} >= px_lo && {1'b0, x_q[i]} <= px_hi) begin
               st_d[i] = LIVRE;
               hit_d   = 1'b1;
            end else if (new_y >= 9'(LIMITE_Y))
               st_d[i] = LIVRE;
            else
               y_d[i] = new_y[7:0];
         end
      end
      // the chosen slot was LIVRE before the tick, so the tick never touches it
      if (ok) begin
         st_d[slot] = ATIVO;
         x_d[slot]  = spawn_x[7:0];
         y_d[slot]  = spawn_y[7:0];
      end

      if (restart) begin
         s1_vld_d = 1'b0; s1_idx_d = '0; s1_vivo_d = 1'b0; s1_bx_d = '0; s1_by_d = '0;
         aceito_d = 1'b0; desc_d = 1'b0; hit_d = 1'b0; cnt_d = '0;
         for (int i = 0; i < MAX_TIROS; i++) begin
            st_d[i] = LIVRE;
            x_d[i]  = '0;
            y_d[i]  = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld_q <= 1'b0; s1_idx_q <= '0; s1_vivo_q <= 1'b0; s1_bx_q <= '0; s1_by_q <= '0;
         aceito_q <= 1'b0; desc_q <= 1'b0; hit_q <= 1'b0; cnt_q <= '0;
         for (int i = 0; i < MAX_TIROS; i++) begin
            st_q[i] <= LIVRE;
            x_q[i]  <= '0;
            y_q[i]  <= '0;
         end
      end else begin
         s1_vld_q <= s1_vld_d; s1_idx_q <= s1_idx_d; s1_vivo_q <= s1_vivo_d;
         s1_bx_q <= s1_bx_d; s1_by_q <= s1_by_d;
         aceito_q <= aceito_d; desc_q <= desc_d; hit_q <= hit_d; cnt_q <= cnt_d;
         for (int i = 0; i < MAX_TIROS; i++) begin
            st_q[i] <= st_d[i];
            x_q[i]  <= x_d[i];
            y_q[i]  <= y_d[i];
         end
      end
   end

   always_comb begin
      tiro_aceito      = aceito_q;
      tiro_descartado  = desc_q;
      jogador_atingido = hit_q;
      for (int i = 0; i < MAX_TIROS; i++) begin
         tiros_ativos[i]   = (st_q[i] == ATIVO);
         tiro_x[8*i +: 8]  = x_q[i];
         tiro_y[8*i +: 8]  = y_q[i];
      end
   end
endmodule
